simple_bus_mem_slave: RTL and testbench
=======================================

Name: simple_bus_mem_slave

Overview:
- Memory-backed slave that consumes simple_bus master transactions.
- Sits directly downstream of the CPU master stage and replaces the behavioural slave tasks with synthesizable RTL.
- Arbitrates ownership via req/gnt, executes single or burst read/write accesses on an internal 256x8 array, and signals each completed beat with rdy.
- The bidirectional data bus is split into wdata and rdata; the bus-level wrapper ties both to data.

Parameters:
- WAIT_STATES, 2, extra cycles inserted between beat launch and memory access (0..15).
- BURST_LEN, 4, beats per burst transaction (1..16).
- INIT_ZERO, 0, if 1 the array is cleared to 0x00 at elaboration; no run-time clear.

Ports:
- clk  input  1  bus clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- avail  input  1  slave may accept ownership; sampled only in IDLE
- req  input  1  master requests bus ownership
- gnt  output  1  ownership granted to master
- start  input  1  transaction launch strobe, sampled while granted and idle
- mode  input  2  [0]: 0 = read, 1 = write; [1]: 0 = single, 1 = burst
- addr  input  8  start address
- wdata  input  8  write data
- rdata  output  8  read data, valid when rdy = 1 on a read
- rdy  output  1  one-cycle pulse per completed beat

Behaviour:
- Reset (async, rst = 1): gnt = 0, rdy = 0, rdata = 0x00, FSM = IDLE, beat and wait counters = 0. Array contents are not altered.
- States: IDLE, GRANTED, WAIT, ACCESS, RELOAD, RELEASE.
- IDLE:
  - req = 1 and avail = 1 → gnt = 1 from the next cycle; go GRANTED.
  - Otherwise stay in IDLE with gnt = 0.
- GRANTED:
  - req = 0 → gnt = 0 next cycle; go IDLE.
  - start = 1 → latch addr, mode and wdata; beat = 0; go WAIT with cnt = WAIT_STATES, or go ACCESS if WAIT_STATES = 0.
- WAIT: cnt decrements each cycle; go ACCESS when cnt reaches 1.
- ACCESS (one cycle):
  - Read: rdata <= mem[a].
  - Write: mem[a] <= latched wdata.
  - rdy = 1 in the following cycle.
  - Beat done and transaction complete (single, or beat = BURST_LEN-1) → go GRANTED, or RELEASE if req was seen low during the transaction.
  - Otherwise: a = a+1 (mod 256, 0xFF wraps to 0x00); beat += 1; go RELOAD.
- RELOAD (one cycle, burst only): sample wdata for the next beat at the end of this cycle; then go WAIT or ACCESS as in GRANTED.
- RELEASE: gnt = 0; go IDLE.
- Latency: start sampled at edge N → rdy high in cycle N+2+WAIT_STATES.
  - Burst beats are spaced WAIT_STATES+2 cycles apart.
  - rdata holds its value until the next read beat.
- Boundary conditions:
  - start while not in GRANTED: ignored.
  - req drop mid-transaction: transaction finishes all beats, then gnt drops.
  - avail drop while granted: no effect.
  - rst mid-transaction: immediate abort; a write committed in an earlier ACCESS cycle is kept; no further beats.
  - req and start high on the same cycle in IDLE: start ignored; the grant cycle must pass first.

Optional Feature:
- Macro: SIMPLE_BUS_PARITY_EN.
- Enabled:
  - Array widens to 9 bits; even parity of wdata is stored on each write.
  - Output perr (1 bit) pulses together with rdy on a read whose stored parity mismatches.
  - perr resets to 0.
- Disabled: no perr port and 8-bit storage; behaviour is otherwise identical.

Test Plan:
- Reset/grant: release rst, avail = 1, req = 1 → gnt = 1 one cycle later; req = 0 → gnt = 0 next cycle; avail = 0 with req = 1 → gnt stays 0.
- Single write/read, WAIT_STATES = 2: write 0xA5 to 0x10, then read 0x10 → rdy exactly 4 cycles after each start; rdata = 0xA5 during the read rdy cycle.
- Burst write wrap: BURST_LEN = 4, start addr 0xFE, wdata 0x11/0x22/0x33/0x44 presented at launch and each RELOAD; burst read from 0xFE → mem[0xFE] = 0x11, mem[0xFF] = 0x22, mem[0x00] = 0x33, mem[0x01] = 0x44; four rdy pulses 4 cycles apart.
- Early req drop: drop req one cycle after start of a burst → all 4 beats complete, then gnt = 0 in the cycle after the final rdy; start pulsed mid-burst → ignored.
- Reset mid-burst: assert rst after the 2nd write beat of a burst to 0x20 → gnt = 0 and rdy = 0 immediately; mem[0x20..0x21] written, mem[0x22..0x23] unchanged.
- Parity (SIMPLE_BUS_PARITY_EN): force a parity bit flip at 0x30 after writing 0x0F, then read 0x30 → perr = 1 and rdy = 1 in the same cycle; a clean address reads with perr = 0.

Source files
------------

// File: rtl/simple_bus_if.sv
// -----------------------------------------------------------------------------
// simple_bus_if
// Handshake and data signals between a simple_bus master and a memory slave.
// The bidirectional data bus is split into wdata (master -> slave) and
// rdata (slave -> master); the bus-level wrapper ties both to data.
//
// Signals:
//   req    master requests bus ownership
//   gnt    slave grants ownership
//   start  transaction launch strobe
//   mode   [0] 0 = read / 1 = write, [1] 0 = single / 1 = burst
//   addr   start address
//   wdata  write data
//   rdata  read data, valid while rdy = 1 on a read
//   rdy    one-cycle pulse per completed beat
//   perr   read parity error, only when SIMPLE_BUS_PARITY_EN is defined
//
// Optional feature macro: SIMPLE_BUS_PARITY_EN
// -----------------------------------------------------------------------------
interface simple_bus_if;
    logic       req;
    logic       gnt;
    logic       start;
    logic [1:0] mode;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdy;
`ifdef SIMPLE_BUS_PARITY_EN
    logic       perr;

    modport master (output req, start, mode, addr, wdata,
                    input  gnt, rdata, rdy, perr);
    modport slave  (input  req, start, mode, addr, wdata,
                    output gnt, rdata, rdy, perr);
`else
    modport master (output req, start, mode, addr, wdata,
                    input  gnt, rdata, rdy);
    modport slave  (input  req, start, mode, addr, wdata,
                    output gnt, rdata, rdy);
`endif
endinterface

// File: rtl/simple_bus_mem_slave.sv
// -----------------------------------------------------------------------------
// simple_bus_mem_slave
// Memory-backed simple_bus slave. Grants ownership via req/gnt, runs single
// or burst read/write transactions on an internal 256 x 8 array and pulses
// rdy once per completed beat. Each beat: optional WAIT_STATES wait cycles,
// one ACCESS cycle, rdy in the cycle after ACCESS.
//
// Ports:
//   clk    bus clock, rising edge
//   rst    asynchronous, active-high reset (array contents are kept)
//   avail  slave may accept ownership; only looked at in IDLE
//   bus    simple_bus_if slave modport (req, gnt, start, mode, addr,
//          wdata, rdata, rdy and, with parity, perr)
//
// Parameters:
//   WAIT_STATES  wait cycles between beat launch and memory access (0..15)
//   BURST_LEN    beats per burst (1..16)
//   INIT_ZERO    1: array starts as 0x00; no run-time clear
//
// Optional feature macro: SIMPLE_BUS_PARITY_EN
//   Stores an even-parity bit with every byte and pulses perr with rdy on a
//   read whose stored parity does not match the stored data.
// -----------------------------------------------------------------------------
module simple_bus_mem_slave #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned BURST_LEN   = 4,
    parameter bit          INIT_ZERO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avail,
    simple_bus_if.slave bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANTED = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ACCESS  = 3'd3;
    localparam logic [2:0] ST_RELOAD  = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    localparam logic [3:0] WS_CNT    = 4'(WAIT_STATES);
    localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);

    // Where a freshly launched beat goes: straight to ACCESS without waits.
    localparam logic [2:0] LAUNCH_ST = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;

`ifdef SIMPLE_BUS_PARITY_EN
    localparam int MEM_W = 9;
`else
    localparam int MEM_W = 8;
`endif

    localparam logic [MEM_W-1:0] MEM_INIT = INIT_ZERO ? '0 : 'x;

`ifdef SIMPLE_BUS_PARITY_EN
    // Even parity bit: makes the total count of ones in {p, d} even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // True when a stored word's parity bit disagrees with its data.
    function automatic logic parity_bad(input logic [8:0] w);
        return (even_parity(w[7:0]) != w[8]);
    endfunction
`endif

    logic [MEM_W-1:0] mem_q [256] = '{default: MEM_INIT};

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] beat_q,  beat_d;
    logic [7:0] addr_q,  addr_d;
    logic [1:0] mode_q,  mode_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rel_q,   rel_d;    // req was seen low during the transaction
    logic       gnt_q,   gnt_d;
    logic       rdy_q,   rdy_d;
    logic [7:0] rdata_q, rdata_d;
    logic       perr_q,  perr_d;

    logic             mem_we_s;
    logic [MEM_W-1:0] mem_wword_s;
    logic [MEM_W-1:0] mem_rword_s;
    logic             last_beat_s;

    assign mem_rword_s = mem_q[addr_q];
    assign last_beat_s = (!mode_q[1]) || (beat_q == BEAT_LAST);

`ifdef SIMPLE_BUS_PARITY_EN
    assign mem_wword_s = {even_parity(wdata_q), wdata_q};
`else
    assign mem_wword_s = wdata_q;
`endif

    // Next-state, transaction bookkeeping and output-register next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        mode_d   = mode_q;
        wdata_d  = wdata_q;
        rel_d    = rel_q;
        rdy_d    = 1'b0;
        rdata_d  = rdata_q;
        perr_d   = 1'b0;
        mem_we_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req && avail) begin
                    state_d = ST_GRANTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANTED: begin
                if (!bus.req) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    addr_d  = bus.addr;
                    mode_d  = bus.mode;
                    wdata_d = bus.wdata;
                    beat_d  = 4'd0;
                    rel_d   = 1'b0;
                    cnt_d   = WS_CNT;
                    state_d = LAUNCH_ST;
                end else begin
                    state_d = ST_GRANTED;
                end
            end

            ST_WAIT: begin
                rel_d = rel_q | ~bus.req;
                // cnt == 1 marks the final wait cycle.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end

            ST_ACCESS: begin
                rdy_d = 1'b1;
                if (mode_q[0]) begin
                    mem_we_s = 1'b1;
                end else begin
                    rdata_d = mem_rword_s[7:0];
`ifdef SIMPLE_BUS_PARITY_EN
                    perr_d  = parity_bad(mem_rword_s);
`endif
                end
                if (last_beat_s) begin
                    // A req drop anywhere in the transaction releases the bus.
                    if (rel_q || !bus.req) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_GRANTED;
                    end
                    rel_d = 1'b0;
                end else begin
                    rel_d   = rel_q | ~bus.req;
                    addr_d  = addr_q + 8'd1;
                    beat_d  = beat_q + 4'd1;
                    state_d = ST_RELOAD;
                end
            end

            ST_RELOAD: begin
                rel_d   = rel_q | ~bus.req;
                wdata_d = bus.wdata;
                cnt_d   = WS_CNT;
                state_d = LAUNCH_ST;
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // gnt is high in every state but IDLE, so it falls on leaving RELEASE.
        gnt_d = (state_d != ST_IDLE);
    end

    // Control and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            beat_q  <= 4'd0;
            addr_q  <= 8'h00;
            mode_q  <= 2'b00;
            wdata_q <= 8'h00;
            rel_q   <= 1'b0;
            gnt_q   <= 1'b0;
            rdy_q   <= 1'b0;
            rdata_q <= 8'h00;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            rel_q   <= rel_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Storage array write port; reset deliberately leaves contents intact.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[addr_q] <= mem_wword_s;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.rdy   = rdy_q;
    assign bus.rdata = rdata_q;
`ifdef SIMPLE_BUS_PARITY_EN
    assign bus.perr  = perr_q;
`else
    logic unused_perr_s;
    assign unused_perr_s = perr_q;
`endif

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Directed testbench for simple_bus_mem_slave (WAIT_STATES = 2, BURST_LEN = 4).
module tb_simple_bus_mem_slave;

    logic clk;
    logic rst;
    logic avail;

    simple_bus_if bus ();

    simple_bus_mem_slave #(
        .WAIT_STATES (2),
        .BURST_LEN   (4),
        .INIT_ZERO   (1'b0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .avail (avail),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] bw [4];
    logic [7:0] br [4];
    int         gap [4];
    logic       last_gnt;
    logic       last_perr;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until rdy is seen, at most 40 cycles.
    task automatic wait_rdy(output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            step();
            n++;
            if (bus.rdy === 1'b1) ok = 1'b1;
        end
    endtask

    // Count rdy pulses over a fixed window.
    task automatic count_rdy(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.rdy === 1'b1) cnt++;
        end
    endtask

    // Single transfer; lat counts edges from the start-sampling edge to rdy.
    task automatic single(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] q, output int lat);
        int   n;
        logic ok;
        bus.start = 1'b1;
        bus.mode  = {1'b0, wr};
        bus.addr  = a;
        bus.wdata = d;
        step();
        bus.start = 1'b0;
        wait_rdy(n, ok);
        chk1("single_rdy_seen", ok, 1'b1);
        lat = n + 1;
        q   = bus.rdata;
`ifdef SIMPLE_BUS_PARITY_EN
        last_perr = bus.perr;
`else
        last_perr = 1'b0;
`endif
    endtask

    // Burst transfer of nbeats pulses observed; bw[] supplies write data.
    task automatic burst(input logic wr, input logic [7:0] a, input int nbeats,
                         input logic drop_req, input logic mid_start);
        int   n;
        int   pre;
        logic ok;
        bus.start = 1'b1;
        bus.mode  = {1'b1, wr};
        bus.addr  = a;
        bus.wdata = bw[0];
        step();
        bus.start = 1'b0;
        pre = 1;
        if (drop_req) bus.req = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wait_rdy(n, ok);
            chk1("burst_rdy_seen", ok, 1'b1);
            gap[i]   = n + pre;
            pre      = 0;
            br[i]    = bus.rdata;
            last_gnt = bus.gnt;
            if (i < 3) bus.wdata = bw[i + 1];
            if (mid_start && i == 0) begin
                bus.start = 1'b1;
                bus.mode  = 2'b01;
                bus.addr  = 8'h90;
                step();
                bus.start = 1'b0;
                pre = 1;
            end
        end
    endtask

    initial begin
        logic [7:0] q;
        int         lat;
        int         cnt;

        rst       = 1'b0;
        avail     = 1'b0;
        bus.req   = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.addr  = 8'h00;
        bus.wdata = 8'h00;
        last_gnt  = 1'b0;
        last_perr = 1'b0;
        #2 rst = 1'b1;
        step();
        step();
        chk1("reset_gnt", bus.gnt, 1'b0);
        chk1("reset_rdy", bus.rdy, 1'b0);
        chk8("reset_rdata", bus.rdata, 8'h00);
        rst = 1'b0;

        // Grant handshake.
        avail = 1'b1; bus.req = 1'b1;
        step();
        chk1("grant_after_req", bus.gnt, 1'b1);
        bus.req = 1'b0;
        step();
        chk1("gnt_drop_after_req_low", bus.gnt, 1'b0);
        avail = 1'b0; bus.req = 1'b1;
        step(); step(); step();
        chk1("no_grant_without_avail", bus.gnt, 1'b0);

        // req and start together in IDLE: start must be ignored.
        avail = 1'b1; bus.start = 1'b1; bus.mode = 2'b01; bus.addr = 8'h50; bus.wdata = 8'hEE;
        step();
        bus.start = 1'b0;
        chk1("grant_with_start", bus.gnt, 1'b1);
        count_rdy(6, cnt);
        chki("idle_start_ignored", cnt, 0);
        avail = 1'b0;
        step(); step();
        chk1("avail_drop_keeps_gnt", bus.gnt, 1'b1);
        avail = 1'b1;

        // Single write / read.
        single(1'b1, 8'h10, 8'hA5, q, lat);
        chki("single_wr_latency", lat, 4);
        single(1'b0, 8'h10, 8'h00, q, lat);
        chki("single_rd_latency", lat, 4);
        chk8("single_rd_data", q, 8'hA5);

        // Burst write with address wrap, then burst read back.
        bw[0] = 8'h11; bw[1] = 8'h22; bw[2] = 8'h33; bw[3] = 8'h44;
        burst(1'b1, 8'hFE, 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chki($sformatf("bwr_gap%0d", i), gap[i], 4);
        bw[0] = 8'h00; bw[1] = 8'h00; bw[2] = 8'h00; bw[3] = 8'h00;
        burst(1'b0, 8'hFE, 4, 1'b0, 1'b0);
        chk8("brd_fe", br[0], 8'h11);
        chk8("brd_ff", br[1], 8'h22);
        chk8("brd_00", br[2], 8'h33);
        chk8("brd_01", br[3], 8'h44);
        for (int i = 0; i < 4; i++) chki($sformatf("brd_gap%0d", i), gap[i], 4);
        single(1'b0, 8'h00, 8'h00, q, lat);
        chk8("wrap_rd_00", q, 8'h33);

        // Early req drop with a stray start mid-burst.
        bw[0] = 8'h01; bw[1] = 8'h02; bw[2] = 8'h03; bw[3] = 8'h04;
        burst(1'b1, 8'h40, 4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) chki($sformatf("drop_gap%0d", i), gap[i], 4);
        chk1("drop_gnt_at_last_rdy", last_gnt, 1'b1);
        step();
        chk1("drop_gnt_after_last_rdy", bus.gnt, 1'b0);
        count_rdy(5, cnt);
        chki("drop_no_extra_rdy", cnt, 0);
        bus.req = 1'b1;
        step();
        chk1("regrant_after_drop", bus.gnt, 1'b1);
        single(1'b0, 8'h43, 8'h00, q, lat);
        chk8("drop_rd_43", q, 8'h04);

        // Reset in the middle of a burst write.
        single(1'b1, 8'h22, 8'h5A, q, lat);
        single(1'b1, 8'h23, 8'h6B, q, lat);
        bw[0] = 8'hC1; bw[1] = 8'hC2; bw[2] = 8'hC3; bw[3] = 8'hC4;
        burst(1'b1, 8'h20, 2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk1("midrst_gnt", bus.gnt, 1'b0);
        chk1("midrst_rdy", bus.rdy, 1'b0);
        step();
        rst = 1'b0;
        count_rdy(6, cnt);
        chki("midrst_no_more_beats", cnt, 0);
        chk1("midrst_regrant", bus.gnt, 1'b1);
        single(1'b0, 8'h20, 8'h00, q, lat);
        chk8("midrst_rd_20", q, 8'hC1);
        single(1'b0, 8'h21, 8'h00, q, lat);
        chk8("midrst_rd_21", q, 8'hC2);
        single(1'b0, 8'h22, 8'h00, q, lat);
        chk8("midrst_rd_22", q, 8'h5A);
        single(1'b0, 8'h23, 8'h00, q, lat);
        chk8("midrst_rd_23", q, 8'h6B);

`ifdef SIMPLE_BUS_PARITY_EN
        // Corrupt a stored parity bit and read it back.
        single(1'b1, 8'h30, 8'h0F, q, lat);
        dut.mem_q[8'h30][8] = ~dut.mem_q[8'h30][8];
        single(1'b0, 8'h30, 8'h00, q, lat);
        chk1("parity_perr_set", last_perr, 1'b1);
        chk8("parity_rd_data", q, 8'h0F);
        single(1'b0, 8'h10, 8'h00, q, lat);
        chk1("parity_clean", last_perr, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
